// File: rtl/glip_uart_pkg.sv
// Shared definitions for the GLIP UART receiver/transmitter family.
//   par_mode_e      : parity mode (none / even / odd)
//   rx_state_e      : receiver FSM state encoding
//   calc_sample_div : clock cycles per oversample tick, clamped to at least 1
package glip_uart_pkg;

    typedef enum logic [1:0] {
        ParNone,
        ParEven,
        ParOdd
    } par_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned calc_sample_div(input int unsigned freq,
                                                    input int unsigned baud,
                                                    input int unsigned oversample);
        int unsigned div;
        div = freq / (baud * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/glip_uart_sample_tick.sv
// Oversample tick generator: free-running divider with synchronous clear.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   clr  : hold the counter at 0 (no tick while asserted)
//   tick : one-cycle pulse every DIV cycles
module glip_uart_sample_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] Last = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == Last) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/glip_uart_rx_framed.sv
// Parametrised UART receiver: 5..8 data bits, none/even/odd parity, 1 or 2 stop
// bits, 3-sample majority vote per bit, break detection, one-entry holding
// register with valid/ready handshake and overrun reporting.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   rx           : asynchronous serial input, idle high
//   out_data     : received word (LSB first on the line)
//   out_valid    : holding register full
//   out_ready    : consumer accepts the word this cycle
//   err_parity   : pulse, parity mismatch (word dropped)
//   err_frame    : pulse, a stop bit sampled low (word dropped)
//   err_overrun  : pulse, good word dropped because the holding register was full
//   break_det    : pulse when a break ends
module glip_uart_rx_framed
    import glip_uart_pkg::*;
#(
    parameter int unsigned FREQ       = 0,  // must be overridden
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter string       PARITY     = "NONE",
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    output logic                 break_det
);

    localparam par_mode_e ParMode = (PARITY == "EVEN") ? ParEven :
                                    (PARITY == "ODD")  ? ParOdd  : ParNone;
    localparam int unsigned SampleDiv = calc_sample_div(FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SampA    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SampB    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SampC    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SampLast = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LastStop = 3'(STOP_BITS - 1);

    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 any_one_q, any_one_d;
    logic                 stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_parity_q, err_parity_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 break_q, break_d;

    logic tick, decide, bit_val, exp_par, stop_bad_now, any_now, deliver;

    // Divider is held in IDLE so sample phase is aligned to the start edge.
    glip_uart_sample_tick #(
        .DIV (SampleDiv)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == StIdle),
        .tick (tick)
    );

    assign decide       = tick && (samp_cnt_q == SampC);
    // Third sample is taken live at the decision tick.
    assign bit_val      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
    assign exp_par      = (^shift_q) ^ (ParMode == ParOdd);
    assign stop_bad_now = stop_bad_q | ~bit_val;
    assign any_now      = any_one_q | bit_val;

    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        smp_d         = smp_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        any_one_d     = any_one_q;
        stop_bad_d    = stop_bad_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
        break_d       = 1'b0;
        deliver       = 1'b0;

        // Sample counter keeps running across states so each decision happens
        // mid-bit and the next bit's samples land in the following bit period.
        if (state_q == StIdle) begin
            samp_cnt_d = '0;
        end else if (tick) begin
            samp_cnt_d = (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + SW'(1);
            if (samp_cnt_q == SampA) smp_d[0] = rx_sync_q;
            if (samp_cnt_q == SampB) smp_d[1] = rx_sync_q;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    any_one_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (decide) state_d = bit_val ? StIdle : StData;
            end
            StData: begin
                if (decide) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    any_one_d = any_now;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        state_d   = (ParMode == ParNone) ? StStop : StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    any_one_d = any_now;
                    par_err_d = (bit_val != exp_par);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (decide) begin
                    if (bit_cnt_q == LastStop) begin
                        state_d = StIdle;
                        if (!any_now) begin
                            state_d = StBreak;
                        end else if (stop_bad_now) begin
                            err_frame_d = 1'b1;
                        end else if (par_err_q) begin
                            err_parity_d = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        stop_bad_d = stop_bad_now;
                        any_one_d  = any_now;
                    end
                end
            end
            StBreak: begin
                if (rx_sync_q) begin
                    break_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A consume in the same cycle frees the slot for the new word.
        if (deliver) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                err_overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            state_q       <= StIdle;
            samp_cnt_q    <= '0;
            smp_q         <= 2'b11;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_err_q     <= 1'b0;
            any_one_q     <= 1'b0;
            stop_bad_q    <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            break_q       <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            smp_q         <= smp_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_err_q     <= par_err_d;
            any_one_q     <= any_one_d;
            stop_bad_q    <= stop_bad_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            break_q       <= break_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign break_det   = break_q;

endmodule

// File: doc/glip_uart_rx_framed.md
# glip_uart_rx_framed

Parametrised UART receiver, successor to the fixed 8N1 receiver in the GLIP UART backend. Supports 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, oversampled majority-vote bit detection, break detection, and a valid/ready output with overrun reporting. It sits between the `uart_rx` pin and the control/ingress path in the `clk_io` domain.

## Interface
- `FREQ`, none (must be set): clock frequency in Hz.
- `BAUD`, 115200: line baud rate.
- `OVERSAMPLE`, 16: samples per bit; even, ≥ 4.
- `DATA_BITS`, 8: 5..8.
- `PARITY`, "NONE": "NONE", "EVEN" or "ODD".
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  single clock; all logic is in this domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  asynchronous serial input, idle high.
- `out_data`  out  DATA_BITS  received word, LSB first on the line.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts.
- `err_parity`  out  1  one-cycle pulse: parity mismatch.
- `err_frame`  out  1  one-cycle pulse: a stop bit sampled low (not a break).
- `err_overrun`  out  1  one-cycle pulse: good word dropped because the holding register was full.
- `break_det`  out  1  one-cycle pulse when a break ends (line returns high).

## Operation
- `rx` passes through a 2-flop synchroniser reset to 1.
- Tick generator: `SAMPLE_DIV = FREQ/(BAUD*OVERSAMPLE)` (integer, ≥ 1). Counter wraps at `SAMPLE_DIV-1` and emits one-cycle `tick`. The counter is held at 0 in IDLE, so phase aligns to the start edge.
- Bit value = majority of 3 samples at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2`, `OVERSAMPLE/2+1` within the bit. The bit decision is made at tick `OVERSAMPLE/2+1`.
- States:
  - IDLE: synced rx = 0 → START.
  - START: decided bit = 1 → IDLE (glitch, no pulse); else → DATA.
  - DATA: shift `DATA_BITS` bits in LSB first, then → PARITY if `PARITY` != "NONE", else → STOP.
  - PARITY: compute the expected bit (even: XOR of data; odd: its inverse), record any mismatch, → STOP.
  - STOP: decide each of `STOP_BITS` bits.
    - All data, parity and stop bits 0 → BREAK.
    - Any stop bit 0 → `err_frame` pulse, word discarded.
    - Parity mismatch → `err_parity` pulse, word discarded.
    - Otherwise deliver the word.
    - Return to IDLE right after the last stop decision (mid-bit), without waiting for the bit end.
  - BREAK: wait for synced rx = 1, then pulse `break_det` and → IDLE.
- Delivery: a one-entry holding register.
  - If `out_valid`=0 or (`out_valid` & `out_ready`) in that cycle: load the word, `out_valid`=1.
  - Else: pulse `err_overrun`, drop the new word, keep the old word.
- `out_data` is stable while `out_valid` & !`out_ready`. The transfer happens on `out_valid` & `out_ready`.
- Frame and parity errors are exclusive, and framing takes priority. Error frames never touch the holding register.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, all pulses 0, state IDLE, synchroniser 1.
- Latency: `out_valid` rises on the cycle after the final stop-bit decision tick. Relative to the rx falling edge this is about `(1+DATA_BITS+P+STOP_BITS-0.5)` bit times plus 3 cycles (P = 1 with parity, 0 without).
- Error pulses are issued in the same cycle that `out_valid` would rise.
- Simultaneous consume and load: the new word is loaded, `out_valid` stays 1, no overrun.
- Reset asserted mid-frame: everything returns to its reset values immediately. After release, the receiver waits for a fresh falling edge; a line already low re-enters START and is treated as a normal start.
- Back-to-back frames with no idle gap are received without loss.

## Structure
- Shared package `glip_uart_pkg`: parity mode constants (NONE/EVEN/ODD), state encoding, and a `SAMPLE_DIV` compute function.
- Sub-module `glip_uart_sample_tick`: divider counter with a synchronous clear. It is reused by the transmitter successor.

## Test plan
Bench setup: `FREQ`=7372800, `BAUD`=115200, `OVERSAMPLE`=16, so `SAMPLE_DIV`=4.
- 8N1, send 0xA5 with `out_ready`=1 → one-cycle `out_valid` with `out_data`=0xA5, no error pulses.
- 7E2, send 0x35 with a wrong parity bit → `err_parity` pulse, `out_valid` stays 0. The following frame 0x35 with correct parity → `out_valid`, `out_data`=0x35.
- 8N1, second stop bit irrelevant; drive the stop bit low with data 0x12 → `err_frame` pulse only. Hold the line low for 20 bit times → no `err_frame`, and one `break_det` pulse after rx returns high.
- `out_ready`=0, send 0x01 then 0x02 back-to-back → `out_data` holds 0x01 and `err_overrun` pulses once. With `out_ready` then set to 1, a single transfer of 0x01 occurs.
- Low glitch of 5 cycles on idle rx → state returns to IDLE, no pulses, no `out_valid`.
- Assert `rst` mid-data of 0x55, release, then send 0xC3 → only 0xC3 is delivered.
